// File: rtl/seg7_capture_if.sv
// Frame bus between the 7-segment capture block and its consumer.
// The capture block is the master: it samples seg/seg_o and offers frames with valid/ready.
interface seg7_capture_if;
    logic [6:0] seg;
    logic       seg_o;
    logic       ready;
    logic       valid;
    logic [3:0] digit;
    logic       err;
    logic       ovf;

    modport master (
        input  seg, seg_o, ready,
        output valid, digit, err, ovf
    );

    modport slave (
        output seg, seg_o, ready,
        input  valid, digit, err, ovf
    );
endinterface

// File: rtl/seg7_capture.sv
// Recovers a digit from a 7-segment bus: synchronise, debounce, decode, deliver over valid/ready.
// Optional error-frame counter (err_clr / err_cnt) is built when SEG7_ERR_COUNT_EN is defined.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg7_capture_if.master bus
`ifdef SEG7_ERR_COUNT_EN
    ,
    input  logic           err_clr,
    output logic [7:0]     err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    state_t     state, next_state;
    logic [7:0] sync1, sync2;
    logic [7:0] cur;
    logic [7:0] ref_q;
    logic [7:0] last_q;
    logic [3:0] cnt_q;
    logic [3:0] digit_q;
    logic       err_q;
    logic       ovf_q;

    logic       load_ref;
    logic       cnt_inc;
    logic       capture;
    logic [3:0] dec_digit;
    logic       dec_err;

    // Returns {err, digit}; anything outside the ten digit shapes is an error.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   return 5'h00;
            7'h30:   return 5'h01;
            7'h6D:   return 5'h02;
            7'h79:   return 5'h03;
            7'h33:   return 5'h04;
            7'h5B:   return 5'h05;
            7'h5F:   return 5'h06;
            7'h70:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h7B:   return 5'h09;
            default: return 5'h1F;
        endcase
    endfunction

    assign cur                  = sync2;
    assign {dec_err, dec_digit} = decode(ref_q[6:0]);

    // NOTE: every flop uses non-blocking assignment and the async reset branch,
    // so all state drops the instant rst rises, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.seg_o, bus.seg};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cur != last_q) next_state = SETTLE;
            end
            SETTLE: begin
                if (cur == last_q)                           next_state = IDLE;
                else if (cur == ref_q && cnt_q == CNT_MAX)   next_state = HOLD;
            end
            HOLD: begin
                if (bus.ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_ref = 1'b0;
        cnt_inc  = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                load_ref = (cur != last_q);
            end
            SETTLE: begin
                if (cur != last_q) begin
                    if (cur != ref_q)           load_ref = 1'b1;
                    else if (cnt_q == CNT_MAX)  capture  = 1'b1;
                    else                        cnt_inc  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load_ref) begin
                ref_q <= cur;
                cnt_q <= 4'd1;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 4'd1;
            end
            // last remembers what was delivered, so an unchanged display is never re-sent.
            if (capture) begin
                last_q  <= ref_q;
                digit_q <= dec_digit;
                err_q   <= dec_err;
                ovf_q   <= ref_q[7];
            end
        end
    end

    assign bus.valid = (state == HOLD);
    assign bus.digit = digit_q;
    assign bus.err   = err_q;
    assign bus.ovf   = ovf_q;

`ifdef SEG7_ERR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     err_cnt <= '0;
        else if (err_clr)                            err_cnt <= '0;
        else if (capture && dec_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized traffic against a
// run-length reference model of the synchronise/debounce/deliver behaviour.
module tb_seg7_capture;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    seg7_capture_if bus();
`ifdef SEG7_ERR_COUNT_EN
    logic       err_clr;
    logic [7:0] err_cnt;
`endif

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .err_clr (err_clr),
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is delivered once a value different from the last delivered
    // one has been seen S+1 consecutive times at the synchroniser output while not holding.
    logic [6:0] digit_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [7:0] m_s1, m_s2, m_last, m_run_val;
    int         m_run;
    bit         m_hold;
    logic [3:0] m_digit;
    bit         m_err, m_ovf;
    int         m_errcnt;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_last = '0; m_run_val = '0; m_run = 0;
        m_hold = 1'b0; m_digit = '0; m_err = 1'b0; m_ovf = 1'b0; m_errcnt = 0;
    endtask

    function automatic void decode_m(input logic [6:0] p, output logic [3:0] d, output bit e);
        d = 4'hF;
        e = 1'b1;
        for (int i = 0; i < 10; i++)
            if (digit_pat[i] == p) begin
                d = 4'(i);
                e = 1'b0;
            end
    endfunction

    // Advances the model by the edge about to occur, using the inputs currently driven.
    task automatic step();
        logic [7:0] cur;
        cur = m_s2;
        if (m_hold) begin
            if (bus.ready) m_hold = 1'b0;
        end else if (cur == m_last) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && cur == m_run_val) m_run++;
            else begin
                m_run_val = cur;
                m_run     = 1;
            end
            if (m_run == S + 1) begin
                decode_m(cur[6:0], m_digit, m_err);
                m_ovf  = cur[7];
                m_hold = 1'b1;
                m_last = cur;
                m_run  = 0;
                if (m_err && m_errcnt < 255) m_errcnt++;
            end
        end
`ifdef SEG7_ERR_COUNT_EN
        if (err_clr) m_errcnt = 0;
`endif
        m_s2 = m_s1;
        m_s1 = {bus.seg_o, bus.seg};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !bus.valid; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.seg = 7'h00; bus.seg_o = 1'b0; bus.ready = 1'b1;
`ifdef SEG7_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
        model_reset();
        #3;
        checks++;
        if ({bus.valid, bus.digit, bus.err, bus.ovf} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0000000", {bus.valid, bus.digit, bus.err, bus.ovf});
        end
`ifdef SEG7_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_cnt got=%0d want=0", err_cnt);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL blank_after_reset valid=%b want=0", bus.valid);
        end
    endtask

    task automatic test_basic();
        bus.seg = 7'h7E; bus.seg_o = 1'b0; bus.ready = 1'b1;
        for (int e = 0; e < 16; e++) begin
            step();
            checks++;
            if (bus.valid !== (e == S + 2)) begin
                errors++;
                $display("FAIL basic_latency edge=%0d valid=%b want=%b", e, bus.valid, e == S + 2);
            end
            if (e == S + 2) begin
                checks++;
                if ({bus.digit, bus.err, bus.ovf} !== {4'd0, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL basic_frame got=%h/%b/%b want=0/0/0", bus.digit, bus.err, bus.ovf);
                end
            end
        end
    endtask

    task automatic test_hold();
        bus.seg = 7'h33; bus.ready = 1'b0;
        wait_valid(20);
        checks++;
        if (bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_timeout valid=%b want=1", bus.valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 5) bus.seg = 7'h5B;
            step();
            checks++;
            if ({bus.valid, bus.digit} !== {1'b1, 4'd4}) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got=%b/%h want=1/4", i, bus.valid, bus.digit);
            end
        end
        bus.ready = 1'b1;
        step();
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept valid=%b want=0", bus.valid);
        end
        wait_valid(20);
        checks++;
        if ({bus.valid, bus.digit} !== {1'b1, 4'd5}) begin
            errors++;
            $display("FAIL hold_second got=%b/%h want=1/5", bus.valid, bus.digit);
        end
    endtask

    task automatic test_glitch();
        bus.seg = 7'h7E; bus.ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        bus.seg = 7'h30;
        step(); step();
        bus.seg = 7'h7E;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (bus.valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch_frame cyc=%0d valid=%b want=0", i, bus.valid);
            end
        end
    endtask

    task automatic test_alternate();
        int frames = 0;
        logic prev = 1'b0;
        bus.ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.seg = ((i / 2) % 2 == 0) ? 7'h79 : 7'h7B;
            step();
            if (bus.valid && !prev) frames++;
            prev = bus.valid;
        end
        checks++;
        if (frames != 0) begin
            errors++;
            $display("FAIL alt_during_toggle frames=%0d want=0", frames);
        end
        bus.seg = 7'h7B;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.valid && !prev) begin
                frames++;
                checks++;
                if (bus.digit !== 4'd9) begin
                    errors++;
                    $display("FAIL alt_digit got=%h want=9", bus.digit);
                end
            end
            prev = bus.valid;
        end
        checks++;
        if (frames != 1) begin
            errors++;
            $display("FAIL alt_frame_count got=%0d want=1", frames);
        end
    endtask

    task automatic test_invalid();
        bus.seg = 7'h01; bus.seg_o = 1'b1; bus.ready = 1'b1;
        wait_valid(20);
        checks++;
        if ({bus.valid, bus.digit, bus.err, bus.ovf} !== {1'b1, 4'hF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL invalid_frame got=%b/%h/%b/%b want=1/f/1/1",
                     bus.valid, bus.digit, bus.err, bus.ovf);
        end
`ifdef SEG7_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_cnt_inc got=%0d want=1", err_cnt);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL err_cnt_clr got=%0d want=0", err_cnt);
        end
`endif
        bus.seg_o = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_async_reset();
        bus.seg = 7'h7B; bus.seg_o = 1'b0; bus.ready = 1'b0;
        wait_valid(20);
        checks++;
        if (bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup valid=%b want=1", bus.valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.valid, bus.digit, bus.err, bus.ovf} !== 7'b0) begin
            errors++;
            $display("FAIL areset_immediate got=%b want=0000000", {bus.valid, bus.digit, bus.err, bus.ovf});
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 0; e < S + 4; e++) begin
            step();
            checks++;
            if (bus.valid !== (e >= S + 2)) begin
                errors++;
                $display("FAIL areset_refresh edge=%0d valid=%b want=%b", e, bus.valid, e >= S + 2);
            end
        end
        checks++;
        if (bus.digit !== 4'd9) begin
            errors++;
            $display("FAIL areset_digit got=%h want=9", bus.digit);
        end
        bus.ready = 1'b1;
        step();
    endtask

    task automatic test_random();
        int hold_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold_left == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.seg = 7'($urandom);
                    1:       bus.seg = 7'h01;
                    default: bus.seg = digit_pat[$urandom_range(0, 9)];
                endcase
                bus.seg_o = ($urandom_range(0, 3) == 0);
                hold_left = $urandom_range(1, 2 * S + 4);
            end
            hold_left--;
            bus.ready = ($urandom_range(0, 2) != 0);
`ifdef SEG7_ERR_COUNT_EN
            err_clr = ($urandom_range(0, 40) == 0);
`endif
            step();
            checks++;
            if ({bus.valid, bus.digit, bus.err, bus.ovf} !== {m_hold, m_digit, m_err, m_ovf}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b/%h/%b/%b want=%b/%h/%b/%b", i,
                         bus.valid, bus.digit, bus.err, bus.ovf, m_hold, m_digit, m_err, m_ovf);
            end
`ifdef SEG7_ERR_COUNT_EN
            checks++;
            if (err_cnt !== 8'(m_errcnt)) begin
                errors++;
                $display("FAIL random_err_cnt cyc=%0d got=%0d want=%0d", i, err_cnt, m_errcnt);
            end
`endif
        end
`ifdef SEG7_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_glitch();
        test_alternate();
        test_invalid();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
